// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for pipeline boundary registers: stall levels, action
// encodings and the bit layout of the default MEM/WB payload.
package pipe_stage_reg_pkg;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam logic [1:0] ST_LOAD   = 2'b00;
  localparam logic [1:0] ST_HOLD   = 2'b01;
  localparam logic [1:0] ST_BUBBLE = 2'b10;
  localparam logic [1:0] ST_FLUSH  = 2'b11;

  // Default payload layout, LSB first; bits above WD_MSB are spare.
  localparam int DEFAULT_DATA_W  = 71;
  localparam int LLBIT_VALUE_BIT = 0;
  localparam int LLBIT_WE_BIT    = 1;
  localparam int WHILO_BIT       = 2;
  localparam int WDATA_LSB       = 3;
  localparam int WDATA_MSB       = 34;
  localparam int WREG_BIT        = 35;
  localparam int WD_LSB          = 36;
  localparam int WD_MSB          = 40;
  localparam int HILO_DATA_W     = 64;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter
  import pipe_stage_reg_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with flush/bubble/hold control driven by the
// ctrl stall vector, plus hold and bubble performance counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int STALL_W = 6,
  parameter int STAGE   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               cnt_clr,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         out_state,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  if ((STAGE < 0) || (STAGE >= STALL_W)) begin : g_bad_stage
    $error("pipe_stage_reg: STAGE=%0d outside 0..%0d", STAGE, STALL_W - 1);
  end

  logic own_stop;
  logic down_stop;
  logic unused_stall;
  logic [1:0] action;

  assign own_stop     = stall[STAGE];
  assign unused_stall = ^stall;

  // The last stage has nobody downstream to wait on.
  if (STAGE < STALL_W - 1) begin : g_down
    assign down_stop = stall[STAGE+1];
  end else begin : g_last
    assign down_stop = NOSTOP;
  end

  always_comb begin
    action = ST_HOLD;
    if (flush) begin
      action = ST_FLUSH;
    end else if ((own_stop == STOP) && (down_stop == NOSTOP)) begin
      action = ST_BUBBLE;
    end else if (own_stop == NOSTOP) begin
      action = ST_LOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_state <= ST_BUBBLE;
    end else begin
      out_state <= action;
      case (action)
        ST_LOAD: begin
          out_valid <= in_valid;
          out_data  <= in_data;
        end
        ST_BUBBLE, ST_FLUSH: begin
          out_valid <= 1'b0;
          out_data  <= '0;
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (action == ST_HOLD),
    .clr (cnt_clr),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc ((action == ST_BUBBLE) || (action == ST_FLUSH)),
    .clr (cnt_clr),
    .cnt (bubble_cnt)
  );

endmodule
